// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and constants for the TPU drain path
package tpu_pkg;

    localparam int TPU_SA_WIDTH     = 16;
    localparam int TPU_ACC_WIDTH    = 32;
    localparam int DRAIN_RD_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } drain_state_e;

    typedef logic [TPU_ACC_WIDTH-1:0] tpu_row_t [TPU_SA_WIDTH];

endpackage

// File: rtl/tpu_drain_fifo.sv
// rtl/tpu_drain_fifo.sv - synchronous row FIFO with a registered head
module tpu_drain_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Head follows the entry that will be at the read pointer next cycle.
            if (push && (empty || (count == CNT_W'(1) && pop))) begin
                head <= push_data;
            end else if (pop && count > CNT_W'(1)) begin
                head <= mem[ptr_inc(rd_ptr)];
            end
        end
    end

endmodule

// File: rtl/tpu_output_drain.sv
// rtl/tpu_output_drain.sv - reads rows from the Output Buffer and streams them out
module tpu_output_drain
    import tpu_pkg::*;
#(
    parameter int ADDR_WIDTH           = 10,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_ACCUM     = 32,
    parameter int FIFO_DEPTH           = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       start_addr,
    input  logic [7:0]                  num_rows,
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_WIDTH-1:0]       rd_addr_out,
    output logic                        rd_en_out,
    input  logic [DATA_WIDTH_ACCUM-1:0] rd_data_in [SYSTOLIC_ARRAY_WIDTH],
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH_ACCUM-1:0] out_data [SYSTOLIC_ARRAY_WIDTH],
    output logic                        out_last
);

    localparam int ROW_W = SYSTOLIC_ARRAY_WIDTH * DATA_WIDTH_ACCUM;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

    drain_state_e state;
    drain_state_e state_nx;

    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [7:0]            issue_cnt;
    logic [7:0]            pop_cnt;
    logic                  rd_pending;
    logic                  accept;
    logic                  pop;
    logic                  push;
    logic                  rd_en;
    logic [ROW_W-1:0]      rd_row;
    logic [ROW_W-1:0]      head_row;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        credit_used;
    logic [CNT_W:0]        credit_limit;

    // DONE accepts a new command so back-to-back starts lose no cycle.
    assign accept    = start && (state == IDLE || state == DONE);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push      = rd_pending && (!fifo_full || pop);

    // Occupancy plus the read in flight, less this cycle's pop, must leave a free slot.
    assign credit_used  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pending};
    assign credit_limit = DEPTH_V + {{CNT_W{1'b0}}, pop};
    assign rd_en        = (state == RUN) && (issue_cnt != 8'd0) && (credit_used < credit_limit);

    assign busy        = (state == RUN) || (state == FLUSH);
    assign done        = (state == DONE);
    assign rd_en_out   = rd_en;
    assign rd_addr_out = addr_cnt;
    assign out_last    = out_valid && (pop_cnt == 8'd1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nx = (num_rows != 8'd0) ? RUN : DONE;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (rd_en && issue_cnt == 8'd1) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (pop && pop_cnt == 8'd1) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            issue_cnt  <= '0;
            pop_cnt    <= '0;
            rd_pending <= 1'b0;
        end else begin
            state      <= state_nx;
            rd_pending <= rd_en;
            if (accept) begin
                addr_cnt  <= start_addr;
                issue_cnt <= num_rows;
                pop_cnt   <= num_rows;
            end else begin
                if (rd_en) begin
                    addr_cnt  <= addr_cnt + 1'b1;
                    issue_cnt <= issue_cnt - 8'd1;
                end
                if (pop) begin
                    pop_cnt <= pop_cnt - 8'd1;
                end
            end
        end
    end

    always_comb begin
        rd_row = '0;
        for (int i = 0; i < SYSTOLIC_ARRAY_WIDTH; i++) begin
            rd_row[i*DATA_WIDTH_ACCUM +: DATA_WIDTH_ACCUM] = rd_data_in[i];
        end
    end

    for (genvar g = 0; g < SYSTOLIC_ARRAY_WIDTH; g++) begin : g_unpack
        assign out_data[g] = head_row[g*DATA_WIDTH_ACCUM +: DATA_WIDTH_ACCUM];
    end

    tpu_drain_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (rd_row),
        .pop       (pop),
        .head      (head_row),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
